mux_pipe_nx1: RTL

MUX_PIPE_NX1 -- requirements
Module: mux_pipe_nx1

---
 rtl/alu_mux_pkg.sv | 13 +
 rtl/mux_nx1.sv | 31 +++
 rtl/mux_pipe_nx1.sv | 68 ++++++
 3 files changed

// File: rtl/alu_mux_pkg.sv
// alu_mux_pkg: shared mode constants and channel-slice helper
//   MODE_DIRECT / MODE_SCAN : values of the mode input
//   chan_lsb(idx, width)    : lowest bit of channel idx in a packed bus
package alu_mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int unsigned chan_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/mux_nx1.sv
// mux_nx1: combinational N-to-1 channel selector
//   in  : CHANNELS*WIDTH packed channels, channel k at [k*WIDTH +: WIDTH]
//   sel : channel index; indices >= CHANNELS select zero
//   out : selected channel
module mux_nx1
    import alu_mux_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 16
) (
    input  logic [CHANNELS*WIDTH-1:0]    in,
    input  logic [$clog2(CHANNELS)-1:0]  sel,
    output logic [WIDTH-1:0]             out
);

    localparam int SEL_W = $clog2(CHANNELS);

    // Table padded to the full select range so out-of-range indices read zero
    logic [WIDTH-1:0] ch [2**SEL_W];

    for (genvar k = 0; k < 2**SEL_W; k++) begin : g_ch
        if (k < CHANNELS) begin : g_real
            assign ch[k] = in[chan_lsb(k, WIDTH) +: WIDTH];
        end else begin : g_pad
            assign ch[k] = '0;
        end
    end

    assign out = ch[sel];

endmodule

// File: rtl/mux_pipe_nx1.sv
// mux_pipe_nx1: registered N-to-1 mux with valid/ready handshake and scan mode
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_data/in_valid/sel : packed channels, offer, direct-mode select
//   in_ready             : !out_valid || out_ready
//   mode                 : 0 = direct (sel), 1 = scan (internal pointer)
//   out_data/out_chan/out_err/out_valid : registered result, index, range error
//   out_ready            : downstream accept
module mux_pipe_nx1
    import alu_mux_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_err,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [SEL_W-1:0] scan_ptr;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] ptr_next;
    logic [WIDTH-1:0] mux_out;
    logic             accept;
    logic             err;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign idx      = (mode == MODE_SCAN) ? scan_ptr : sel;
    assign err      = 32'(idx) >= CHANNELS;
    assign ptr_next = (32'(scan_ptr) == CHANNELS - 1) ? '0 : scan_ptr + SEL_W'(1);

    mux_nx1 #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_mux (
        .in  (in_data),
        .sel (idx),
        .out (mux_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            out_err   <= 1'b0;
            scan_ptr  <= '0;
        end else begin
            // Held word stays until drained; a new accept overwrites on the same edge
            out_valid <= accept || (out_valid && !out_ready);
            if (accept) begin
                out_data <= mux_out;
                out_chan <= idx;
                out_err  <= err;
                if (mode == MODE_SCAN)
                    scan_ptr <= ptr_next;
            end
        end
    end

endmodule
